random_sample_collector: RTL and testbench
==========================================

# random_sample_collector

Consumer side of the random number generator in the MCMC solver datapath. Requests samples from the generator via its enable input, discards a configurable burn-in, range-checks each sample against the active [min, max] window, and buffers accepted samples in a small FIFO with a valid/ready output toward the variable-update logic. Throttles the generator so the FIFO never overflows.

## Interface
- WIDTH, 8, sample width (two's complement)
- DEPTH, 4, FIFO entries (power of two, ≥2)
- WARMUP, 2, burn-in samples discarded at the start of every run

- in_clock  input  1  system clock, rising edge
- in_reset  input  1  asynchronous, active-low reset
- in_start  input  1  one-cycle pulse: begin a run; ignored while out_busy=1
- in_count  input  8  samples to request after burn-in; latched on in_start
- in_min  input  WIDTH signed  lower bound, inclusive; latched on in_start
- in_max  input  WIDTH signed  upper bound, inclusive; latched on in_start
- out_gen_enable  output  1  enable to generator; one sample requested per high cycle
- in_random  input  WIDTH signed  generator output, valid one cycle after a request
- out_data  output  WIDTH signed  FIFO head
- out_valid  output  1  FIFO non-empty
- in_ready  input  1  consumer accepts out_data when out_valid & in_ready
- out_busy  output  1  run in progress
- out_done  output  1  one-cycle pulse at end of run
- out_error_count  output  8  out-of-range samples this run, saturates at 255

## Operation
- FSM: IDLE, BURN, COLLECT, DONE.
- IDLE: in_start=1 → latch in_count/in_min/in_max, clear out_error_count, remaining=in_count; go BURN (WARMUP>0) else COLLECT.
- BURN: out_gen_enable=1 every cycle until WARMUP requests issued; returned samples discarded unchecked; after last burn sample returns → COLLECT.
- COLLECT: out_gen_enable=1 iff remaining>0 and (fifo_count + pending) < DEPTH, pending = request issued previous cycle. Each request decrements remaining. Returned sample: in range (min ≤ s ≤ max, signed) → push; else discard, out_error_count++ (saturating). Discarded samples still consume a request. When remaining=0 and no sample pending → DONE.
- DONE: out_done=1 for one cycle → IDLE. Done does not wait for FIFO drain.
- in_count=0: BURN still runs, then COLLECT exits immediately; out_done after burn.
- min > max: every sample out of range; run completes with error_count=in_count (capped 255).
- FIFO: pop on out_valid & in_ready; simultaneous push and pop at any fill level legal; count unchanged.
- in_start while busy: ignored, latched values unchanged.
- FIFO contents persist across runs until popped; new run does not flush.

## Timing
- Reset values: out_gen_enable=0, out_valid=0, out_data=0, out_busy=0, out_done=0, out_error_count=0; FSM=IDLE; FIFO empty.
- Reset mid-run: all state cleared asynchronously, FIFO flushed, generator enable drops immediately.
- in_start sampled at edge t → out_busy=1 and out_gen_enable=1 (if WARMUP>0 or in_count>0) after edge t.
- Request high in cycle t → in_random sampled at edge t+1 → out_valid=1 after edge t+1 if pushed (latency 1 from request edge).
- Full-rate: with in_ready=1 continuously, one request per cycle, no stalls.
- out_busy falls the same edge out_done rises... no: out_busy=0 from the cycle after out_done.

## Configuration
- RSC_RANGE_CHECK_EN defined: range check and error counter as above.
- Undefined: every collected sample pushed regardless of bounds; in_min/in_max ignored; out_error_count tied to 0.

## Test plan
- WARMUP=2, in_count=5, range [0,5], generator seeded 1, in_ready=1 → exactly 7 enable cycles, 5 in-range words out, out_done once, error_count=0.
- Range [-20,-10] with generator producing mixed values, in_count=20 → pushed words all in [-20,-10]; pushed + error_count = 20.
- in_ready=0, in_count=10, DEPTH=4 → out_gen_enable stops with FIFO at 4, no overflow; release in_ready → remaining 6 delivered, in order.
- in_count=0 → 2 burn requests, out_done 1 cycle after last burn sample, no data pushed.
- Reset asserted mid-COLLECT with FIFO holding 3 → out_valid=0, out_gen_enable=0 immediately; new in_start behaves as fresh run.
- in_start pulse while busy with in_count=99 → ignored; run completes with original count.

Source files
------------

// File: rtl/random_sample_collector.sv
// Consumer side of the MCMC random number generator: burn-in discard, throttled requests, small output FIFO.
// Define RSC_RANGE_CHECK_EN to enable the [min, max] window check and the out-of-range counter.
module random_sample_collector #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int WARMUP = 2
) (
  input  logic                    in_clock,
  input  logic                    in_reset,
  input  logic                    in_start,
  input  logic [7:0]              in_count,
  input  logic signed [WIDTH-1:0] in_min,
  input  logic signed [WIDTH-1:0] in_max,
  output logic                    out_gen_enable,
  input  logic signed [WIDTH-1:0] in_random,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    in_ready,
  output logic                    out_busy,
  output logic                    out_done,
  output logic [7:0]              out_error_count
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int CWX = CW + 1;
  localparam int BW  = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [CWX-1:0] DEPTH_W  = CWX'(DEPTH);
  localparam logic [BW-1:0]  WARMUP_W = BW'(WARMUP);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BURN    = 2'd1;
  localparam logic [1:0] S_COLLECT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]              state;
  logic [7:0]              remaining;
  logic [BW-1:0]           burn_issued;
  logic                    pending;
  logic [CW-1:0]           fifo_count;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic signed [WIDTH-1:0] mem [DEPTH];
  logic                    sample;
  logic                    in_range;
  logic                    push;
  logic                    pop;

  // A request is only issued if its sample is guaranteed a slot, counting the one still in flight.
  always_comb begin
    out_gen_enable = 1'b0;
    case (state)
      S_BURN:    out_gen_enable = (burn_issued != WARMUP_W);
      S_COLLECT: out_gen_enable = (remaining != 8'd0) &&
                                  (({1'b0, fifo_count} + CWX'(pending)) < DEPTH_W);
      default:   out_gen_enable = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      state       <= S_IDLE;
      remaining   <= 8'd0;
      burn_issued <= '0;
      pending     <= 1'b0;
    end else begin
      pending <= out_gen_enable;
      case (state)
        S_IDLE: begin
          if (in_start) begin
            remaining   <= in_count;
            burn_issued <= '0;
            state       <= (WARMUP > 0) ? S_BURN : S_COLLECT;
          end
        end
        S_BURN: begin
          if (out_gen_enable) burn_issued <= burn_issued + BW'(1);
          else if (pending)   state <= S_COLLECT;
        end
        S_COLLECT: begin
          if (out_gen_enable) remaining <= remaining - 8'd1;
          if (remaining == 8'd0 && !pending) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign sample = pending && (state == S_COLLECT);

`ifdef RSC_RANGE_CHECK_EN
  logic signed [WIDTH-1:0] lo;
  logic signed [WIDTH-1:0] hi;
  logic [7:0]              errors;

  assign in_range = (in_random >= lo) && (in_random <= hi);

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      lo     <= '0;
      hi     <= '0;
      errors <= 8'd0;
    end else if (state == S_IDLE && in_start) begin
      lo     <= in_min;
      hi     <= in_max;
      errors <= 8'd0;
    end else if (sample && !in_range && errors != 8'hFF) begin
      errors <= errors + 8'd1;
    end
  end

  assign out_error_count = errors;
`else
  logic unused_bounds;
  assign unused_bounds   = ^{in_min, in_max};
  assign in_range        = 1'b1;
  assign out_error_count = 8'd0;
`endif

  assign push      = sample && in_range;
  assign pop       = out_valid && in_ready;
  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; out_data is gated by out_valid so stale words never show.
  always_ff @(posedge in_clock) begin
    if (push) mem[wr_ptr] <= in_random;
  end

  assign out_busy = (state != S_IDLE);
  assign out_done = (state == S_DONE);

endmodule

// File: tb/tb_random_sample_collector.sv
// Self-checking bench for random_sample_collector: registered-generator stub, queue model of the
// FIFO and error counter, plus directed runs with hand-computed expectations.
module tb_random_sample_collector;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 4;
  localparam int WARMUP = 2;
  localparam logic signed [7:0] JUNK = 8'sh5A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b1;
  logic [7:0] count = 8'd0;
  logic signed [7:0] min_v = 8'sd0;
  logic signed [7:0] max_v = 8'sd0;
  logic signed [7:0] random = 8'sd0;
  logic gen_enable, valid, busy, done;
  logic signed [7:0] data;
  logic [7:0] error_count;

  always #5 clk = ~clk;

  random_sample_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WARMUP(WARMUP)) dut (
    .in_clock(clk), .in_reset(rst_n), .in_start(start), .in_count(count),
    .in_min(min_v), .in_max(max_v), .out_gen_enable(gen_enable), .in_random(random),
    .out_data(data), .out_valid(valid), .in_ready(ready), .out_busy(busy),
    .out_done(done), .out_error_count(error_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

`ifdef RSC_RANGE_CHECK_EN
  localparam bit RANGE_ON = 1'b1;
`else
  localparam bit RANGE_ON = 1'b0;
`endif

  // Model state: run parameters, generator queue, expected FIFO contents and error count.
  int gen_q[$];
  int mq[$];
  int popped[$];
  int exp_q[$];
  int m_min, m_max;
  int req_idx, err_m, done_seen;
  int r_idx, p_idx, r_val, p_val;
  bit had_req, had_pop, presented, prev_busy, prev_done;

  function automatic bit in_rng(input int v);
    return !RANGE_ON || (v >= m_min && v <= m_max);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      err_m = 0; req_idx = 0;
      had_req = 0; had_pop = 0; presented = 0; prev_busy = 0; prev_done = 0;
      random = JUNK;
      check("rst_gen_enable", gen_enable, 0);
      check("rst_valid", valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_data", data, 0);
      check("rst_error_count", error_count, 0);
    end else begin
      // Effects of the edge just passed: pop, then the sample the DUT took from the generator.
      if (had_pop && mq.size() != 0) void'(mq.pop_front());
      if (presented && p_idx >= WARMUP) begin
        if (in_rng(p_val)) mq.push_back(p_val);
        else if (err_m < 255) err_m++;
      end
      if (busy && !prev_busy) begin
        req_idx = 0;
        err_m = 0;
      end
      check("fifo_bound", int'(mq.size() <= DEPTH), 1);
      check("valid", valid, int'(mq.size() != 0));
      if (valid && mq.size() != 0) check("data", data, mq[0]);
      check("error_count", error_count, err_m);
      if (gen_enable) check("enable_while_busy", busy, 1);
      if (prev_done) begin
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
      end
      if (done) done_seen++;
      // The generator answers one cycle after it saw a request.
      if (had_req) begin
        random = 8'(r_val);
        presented = 1; p_idx = r_idx; p_val = r_val;
      end else begin
        random = JUNK;
        presented = 0;
      end
      had_req = gen_enable;
      if (had_req) begin
        r_idx = req_idx;
        req_idx++;
        r_val = (gen_q.size() != 0) ? gen_q.pop_front() : 51;
      end
      had_pop = valid && ready;
      if (had_pop) popped.push_back(int'(data));
      prev_busy = busy;
      prev_done = done;
    end
  end

  task automatic start_run(input int n, input int lo, input int hi);
    @(posedge clk); #1;
    m_min = lo; m_max = hi;
    popped.delete();
    count = 8'(n); min_v = 8'(lo); max_v = 8'(hi); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("enable_after_start", gen_enable, 1);
  endtask

  task automatic wait_done(input string name);
    int seen = done_seen;
    int n = 0;
    while (done_seen == seen && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check(name, int'(done_seen != seen), 1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    ready = 1'b1;
    while ((valid || mq.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, valid, 0);
  endtask

  initial begin
    int d0;
    int exp_err;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("post_reset_valid", valid, 0);
    check("post_reset_enable", gen_enable, 0);
    check("post_reset_busy", busy, 0);

    // T1: burn 2 (out-of-window values, never checked), 5 in-range words delivered in order.
    gen_q = {77, -3, 0, 5, 3, 1, 4};
    d0 = done_seen;
    start_run(5, 0, 5);
    wait_done("t1_done");
    check("t1_requests", req_idx, 7);
    check("t1_errors", error_count, 0);
    repeat (3) @(posedge clk);
    check("t1_done_once", done_seen - d0, 1);
    drain("t1_drain");
    exp_q = {0, 5, 3, 1, 4};
    check("t1_words", popped.size(), 5);
    for (int i = 0; i < 5 && i < popped.size(); i++) check("t1_word", popped[i], exp_q[i]);

    // T4: in_count=0 -> two burn requests, done four edges after the start edge, nothing pushed.
    gen_q = {11, 12};
    start_run(0, -128, 127);
    repeat (3) @(posedge clk);
    #1 check("t4_not_done_yet", done, 0);
    @(posedge clk); #1;
    check("t4_done_cycle", done, 1);
    check("t4_requests", req_idx, 2);
    check("t4_no_data", valid, 0);
    @(posedge clk); #1;
    check("t4_idle_after", busy, 0);

    // T2: window [-20,-10] against mixed values incl. both bounds and their neighbours.
    gen_q = {1, 2, -20, -10, -21, -9, -15, 0, 127, -128, -11, -19,
             -12, 5, -14, -30, -13, -10, -20, 100, -16, -1};
    start_run(20, -20, -10);
    wait_done("t2_done");
    exp_err = RANGE_ON ? 9 : 0;
    check("t2_errors", error_count, exp_err);
    drain("t2_drain");
    check("t2_pushed", popped.size(), 20 - exp_err);
    if (RANGE_ON)
      for (int i = 0; i < popped.size(); i++)
        check("t2_in_window", int'(popped[i] >= -20 && popped[i] <= -10), 1);

    // T3: consumer stalled -> requests stop with the FIFO full, then 10 words in order.
    ready = 1'b0;
    gen_q = {5, 6, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    start_run(10, -128, 127);
    repeat (20) @(posedge clk);
    #1;
    check("t3_stalled_enable", gen_enable, 0);
    check("t3_stalled_requests", req_idx, 6);
    check("t3_stalled_busy", busy, 1);
    check("t3_stalled_valid", valid, 1);
    ready = 1'b1;
    wait_done("t3_done");
    drain("t3_drain");
    check("t3_words", popped.size(), 10);
    for (int i = 0; i < 10 && i < popped.size(); i++) check("t3_order", popped[i], i + 1);

    // T5: reset mid-collect with three words buffered, then a fresh run.
    ready = 1'b0;
    gen_q = {0, 0, 1, 2, 3, 4, 5, 6, 7, 8};
    start_run(8, -128, 127);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk); #1;
      if (mq.size() == 3) break;
    end
    check("t5_reached_3", mq.size(), 3);
    rst_n = 1'b0;
    #1;
    check("t5_valid_drops", valid, 0);
    check("t5_enable_drops", gen_enable, 0);
    check("t5_busy_drops", busy, 0);
    check("t5_data_cleared", data, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ready = 1'b1;
    gen_q = {9, 9, 7, 8, 9};
    start_run(3, 0, 20);
    wait_done("t5_done");
    drain("t5_drain");
    exp_q = {7, 8, 9};
    check("t5_words", popped.size(), 3);
    for (int i = 0; i < 3 && i < popped.size(); i++) check("t5_word", popped[i], exp_q[i]);

    // T6: start pulse while busy with in_count=99 and a wide window must be ignored.
    gen_q = {1, 1, 10, 60, 20, 30};
    start_run(4, 0, 50);
    @(posedge clk); #1;
    count = 8'd99; min_v = -8'sd128; max_v = 8'sd127; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t6_done");
    check("t6_requests", req_idx, 6);
    exp_err = RANGE_ON ? 1 : 0;
    check("t6_errors", error_count, exp_err);
    drain("t6_drain");
    check("t6_words", popped.size(), 4 - exp_err);

    // T7: min > max -> every collected sample is out of range.
    gen_q = {0, 0, 0, 1, -1, 5, 10, -10, 127, -128};
    start_run(8, 10, -10);
    wait_done("t7_done");
    exp_err = RANGE_ON ? 8 : 0;
    check("t7_errors", error_count, exp_err);
    drain("t7_drain");
    check("t7_words", popped.size(), 8 - exp_err);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
